// File: rtl/eth_sd_pkg.sv
// eth_sd_pkg: shared state encoding, sector geometry and byte-lane maps for the eth->SD reader.
package eth_sd_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
   localparam int SD_SECTOR_BYTES = 512;
   localparam int BYTES_PER_WORD = 4;
   localparam logic [1:0] MSB_LANE [BYTES_PER_WORD] = '{2'd3, 2'd2, 2'd1, 2'd0};
   localparam logic [1:0] LSB_LANE [BYTES_PER_WORD] = '{2'd0, 2'd1, 2'd2, 2'd3};
   function automatic logic [1:0] lane_of(input logic lsb, input logic [1:0] idx);
      return lsb ? LSB_LANE[idx] : MSB_LANE[idx];
   endfunction
endpackage

// File: rtl/eth_sd_byte_unpack.sv
// eth_sd_byte_unpack: holds the current FIFO word and selects the byte lane to emit.
module eth_sd_byte_unpack import eth_sd_pkg::*; #(
   parameter string BYTE_ORDER = "MSB_FIRST"
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        load,
   input  logic        advance,
   input  logic [31:0] data,
   output logic [1:0]  byte_idx,
   output logic        last_byte,
   output logic [7:0]  sd_data
);
   localparam bit LSB = BYTE_ORDER == "LSB_FIRST";
   logic [31:0] word_buf;
   logic [1:0]  lane;
   // A load restarts the lane walk; advance wraps 3->0 at a word boundary.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         word_buf <= '0;
         byte_idx <= '0;
      end else if (load) begin
         word_buf <= data;
         byte_idx <= '0;
      end else if (clear) byte_idx <= '0;
      else if (advance) byte_idx <= byte_idx + 2'd1;
   assign lane = lane_of(LSB, byte_idx);
   assign sd_data = word_buf[{lane, 3'b000} +: 8];
   assign last_byte = byte_idx == 2'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/eth_sd_sector_reader.sv
// eth_sd_sector_reader: pops 32-bit FIFO words and streams one framed sector of bytes per sec_start.
module eth_sd_sector_reader import eth_sd_pkg::*; #(
   parameter int    SECTOR_WORDS = 128,
   parameter string BYTE_ORDER   = "MSB_FIRST",
   parameter int    CNT_WIDTH    = 32,
   parameter int    STALL_WIDTH  = 16
) (
   input  logic                   rd_clk,
   input  logic                   rd_rst,
   input  logic                   sec_start,
   input  logic                   sec_abort,
   output logic                   busy,
   output logic                   fifo_rd_en,
   input  logic                   fifo_rd_vld,
   input  logic [31:0]            fifo_rd_data,
   output logic [7:0]             sd_data,
   output logic                   sd_vld,
   input  logic                   sd_rdy,
   output logic                   sd_sof,
   output logic                   sd_eof,
   output logic                   sec_done,
   output logic [CNT_WIDTH-1:0]   sec_cnt,
   output logic [STALL_WIDTH-1:0] stall_cnt
);
   localparam int WW = $clog2(SECTOR_WORDS);
   state_t        state;
   logic [WW-1:0] word_idx;
   logic [1:0]    byte_idx;
   logic          last_byte, last_word, xfer, pop, start_ok;
   assign last_word  = word_idx == WW'(SECTOR_WORDS - 1);
   assign busy       = state != IDLE;
   assign sd_vld     = state == SHIFT && !sec_abort;
   assign xfer       = sd_vld && sd_rdy;
   // In SHIFT the next word is popped alongside the last byte so the stream has no bubble.
   assign fifo_rd_en = !sec_abort && (state == LOAD || (state == SHIFT && last_byte && sd_rdy && !last_word));
   assign pop        = fifo_rd_en && fifo_rd_vld;
   assign sd_sof     = sd_vld && word_idx == '0 && byte_idx == 2'd0;
   assign sd_eof     = sd_vld && last_word && last_byte;
   assign sec_done   = state == DONE && !sec_abort;
   assign start_ok   = state == IDLE && sec_start && !sec_abort;
   eth_sd_byte_unpack #(.BYTE_ORDER(BYTE_ORDER)) u_unpack (
      .clk(rd_clk), .rst(rd_rst), .clear(start_ok), .load(pop), .advance(xfer),
      .data(fifo_rd_data), .byte_idx(byte_idx), .last_byte(last_byte), .sd_data(sd_data)
   );
   always_ff @(posedge rd_clk or posedge rd_rst)
      if (rd_rst) begin
         state     <= IDLE;
         word_idx  <= '0;
         sec_cnt   <= '0;
         stall_cnt <= '0;
      end else if (sec_abort) state <= IDLE;
      else case (state)
         IDLE: if (sec_start) begin
            state     <= LOAD;
            word_idx  <= '0;
            stall_cnt <= '0;
         end
         LOAD: if (fifo_rd_vld) state <= SHIFT;
            else if (~&stall_cnt) stall_cnt <= stall_cnt + STALL_WIDTH'(1);
         SHIFT: if (xfer && last_byte) begin
            if (last_word) state <= DONE;
            else begin
               word_idx <= word_idx + WW'(1);
               if (!fifo_rd_vld) state <= LOAD;
            end
         end
         DONE: begin
            sec_cnt <= sec_cnt + CNT_WIDTH'(1);
            state   <= IDLE;
         end
      endcase
endmodule

// File: tb/tb_eth_sd_sector_reader.sv
// tb_eth_sd_sector_reader: directed checks of framing, handshake, stalls, abort and reset.
module tb_eth_sd_sector_reader;
   logic clk = 0, rst = 1, start = 0, abort = 0, rdy = 1, s2_start = 0;
   logic rd_en, vld, sd_vld, sof, eof, done, busy;
   logic [31:0] rdata, sec_cnt;
   logic [15:0] stall_cnt;
   logic [7:0]  sd_data;
   logic s2_busy, s2_rd_en, s2_vld, s2_sof, s2_eof, s2_done;
   logic [7:0]  s2_data;
   logic [31:0] s2_cnt;
   logic [15:0] s2_stall;
   logic [31:0] mem [0:2047];
   int wr_ptr = 0, rd_ptr = 0, cyc = 0, checks = 0, errors = 0, unstable = 0;
   logic [7:0] bq[$];
   bit sq[$], eq[$];
   int xq[$], dq[$], vq[$];
   logic hold = 0;
   logic [7:0] hold_d = 0;

   always #5 clk = ~clk;
   assign vld = rd_ptr < wr_ptr;
   assign rdata = mem[rd_ptr];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rd_en && vld) rd_ptr <= rd_ptr + 1;
   end
   // Transfer log plus a hold-stability watch on sd_data.
   always @(negedge clk) begin
      if (hold && sd_vld && sd_data !== hold_d) unstable = unstable + 1;
      hold = sd_vld && !rdy;
      hold_d = sd_data;
      if (sd_vld && sof) vq.push_back(cyc);
      if (sd_vld && rdy) begin
         bq.push_back(sd_data); sq.push_back(sof); eq.push_back(eof); xq.push_back(cyc);
      end
      if (done) dq.push_back(cyc);
   end

   eth_sd_sector_reader dut (
      .rd_clk(clk), .rd_rst(rst), .sec_start(start), .sec_abort(abort), .busy(busy),
      .fifo_rd_en(rd_en), .fifo_rd_vld(vld), .fifo_rd_data(rdata), .sd_data(sd_data),
      .sd_vld(sd_vld), .sd_rdy(rdy), .sd_sof(sof), .sd_eof(eof), .sec_done(done),
      .sec_cnt(sec_cnt), .stall_cnt(stall_cnt)
   );
   eth_sd_sector_reader #(.SECTOR_WORDS(2), .BYTE_ORDER("LSB_FIRST")) dut2 (
      .rd_clk(clk), .rd_rst(rst), .sec_start(s2_start), .sec_abort(1'b0), .busy(s2_busy),
      .fifo_rd_en(s2_rd_en), .fifo_rd_vld(1'b1), .fifo_rd_data(32'hAABBCCDD), .sd_data(s2_data),
      .sd_vld(s2_vld), .sd_rdy(1'b1), .sd_sof(s2_sof), .sd_eof(s2_eof), .sec_done(s2_done),
      .sec_cnt(s2_cnt), .stall_cnt(s2_stall)
   );

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic load_words(int n, int vis);
      for (int k = 0; k < n; k++) begin
         logic [7:0] b;
         b = 8'(4 * k);
         mem[wr_ptr + k] = {b, b + 8'd1, b + 8'd2, b + 8'd3};
      end
      wr_ptr += vis;
   endtask
   task automatic start_sec(output int t0);
      start = 1;
      t0 = cyc;
      tick(1);
      start = 0;
   endtask
   task automatic wait_done(string tag, int d0, int limit);
      int n = 0;
      while (dq.size() == d0 && n < limit) begin tick(1); n++; end
      chk({tag, "_done_seen"}, 64'(dq.size() > d0), 1);
   endtask
   task automatic check_stream(string tag, int b0, int off);
      int bad = 0, ns = 0, ne = 0;
      chk({tag, "_len"}, bq.size() - b0, 512);
      for (int i = b0; i < bq.size(); i++) begin
         if (bq[i] !== 8'(off + i - b0)) bad++;
         ns += int'(sq[i]);
         ne += int'(eq[i]);
      end
      chk({tag, "_data_bad"}, bad, 0);
      chk({tag, "_sof_cnt"}, ns, 1);
      chk({tag, "_sof_pos"}, sq[b0], 1);
      chk({tag, "_eof_cnt"}, ne, 1);
      chk({tag, "_eof_pos"}, eq[bq.size() - 1], 1);
   endtask

   initial begin
      int t0, b0, d0, r0, u0;
      tick(2);
      chk("rst_busy", busy, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_sd_vld", sd_vld, 0);
      chk("rst_sd_data", sd_data, 0);
      chk("rst_sof_eof_done", {sof, eof, done}, 0);
      chk("rst_sec_cnt", sec_cnt, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      rst = 0;
      tick(2);

      // Full sector, FIFO preloaded, sd_rdy high.
      load_words(128, 128);
      b0 = bq.size(); d0 = dq.size();
      start_sec(t0);
      wait_done("t1", d0, 700);
      check_stream("t1", b0, 0);
      chk("t1_first_cycle", xq[b0] - t0, 2);
      chk("t1_contiguous", xq[b0 + 511] - xq[b0], 511);
      chk("t1_done_cycle", dq[d0] - t0, 514);
      tick(1);
      chk("t1_sec_cnt", sec_cnt, 1);
      chk("t1_stall_cnt", stall_cnt, 0);
      chk("t1_idle", busy, 0);

      // LSB_FIRST instance: DD,CC,BB,AA.
      s2_start = 1; t0 = cyc; tick(1); s2_start = 0;
      tick(1);
      chk("lsb_b0", s2_data, 8'hDD);
      chk("lsb_sof", {s2_vld, s2_sof}, 2'b11);
      tick(1); chk("lsb_b1", s2_data, 8'hCC);
      tick(1); chk("lsb_b2", s2_data, 8'hBB);
      tick(1); chk("lsb_b3", s2_data, 8'hAA);
      tick(5); chk("lsb_done_cycle", {32'(cyc - t0), 31'd0, s2_done}, {32'd10, 32'd1});

      // sd_rdy toggling: every held byte stays put.
      load_words(128, 128);
      b0 = bq.size(); d0 = dq.size(); r0 = rd_ptr; u0 = unstable;
      start_sec(t0);
      while (dq.size() == d0 && cyc - t0 < 1200) begin
         rdy = ((cyc - t0) % 2) == 1;
         tick(1);
      end
      rdy = 1;
      chk("t3_done_seen", 64'(dq.size() > d0), 1);
      check_stream("t3", b0, 0);
      chk("t3_unstable", unstable - u0, 0);
      chk("t3_span", xq[b0 + 511] - vq[vq.size() - 2] + 1, 1024);
      chk("t3_pops", rd_ptr - r0, 128);
      tick(1);
      chk("t3_sec_cnt", sec_cnt, 2);

      // FIFO runs dry after three words for ten cycles.
      load_words(128, 3);
      b0 = bq.size(); d0 = dq.size();
      start_sec(t0);
      while (cyc < t0 + 24) tick(1);
      chk("t4_stall_cnt", stall_cnt, 10);
      chk("t4_waiting", {busy, sd_vld, rd_en}, 3'b101);
      wr_ptr += 125;
      wait_done("t4", d0, 700);
      check_stream("t4", b0, 0);
      chk("t4_gap", xq[b0 + 12] - xq[b0 + 11], 12);
      chk("t4_done_cycle", dq[d0] - t0, 525);
      tick(1);
      chk("t4_stall_kept", stall_cnt, 10);
      chk("t4_sec_cnt", sec_cnt, 3);

      // Abort on byte 37, then restart from word 10.
      load_words(138, 138);
      b0 = bq.size(); d0 = dq.size(); r0 = rd_ptr;
      start_sec(t0);
      while (cyc < t0 + 39) tick(1);
      abort = 1;
      #1;
      chk("t5_abort_outs", {sd_vld, sof, eof, rd_en}, 0);
      tick(1);
      abort = 0;
      chk("t5_idle", busy, 0);
      tick(5);
      chk("t5_no_done", dq.size() - d0, 0);
      chk("t5_bytes", bq.size() - b0, 37);
      chk("t5_pops", rd_ptr - r0, 10);
      chk("t5_sec_cnt", sec_cnt, 3);
      b0 = bq.size(); d0 = dq.size();
      start_sec(t0);
      wait_done("t5r", d0, 700);
      check_stream("t5r", b0, 40);
      tick(1);
      chk("t5r_sec_cnt", sec_cnt, 4);

      // sec_start while in SHIFT and in DONE is ignored.
      load_words(128, 128);
      b0 = bq.size(); d0 = dq.size(); r0 = rd_ptr;
      start_sec(t0);
      while (cyc < t0 + 100) tick(1);
      start = 1; tick(1); start = 0;
      while (cyc < t0 + 514) tick(1);
      chk("t6_in_done", done, 1);
      start = 1; tick(1); start = 0;
      tick(10);
      chk("t6_one_done", dq.size() - d0, 1);
      chk("t6_bytes", bq.size() - b0, 512);
      chk("t6_pops", rd_ptr - r0, 128);
      chk("t6_idle", busy, 0);
      chk("t6_sec_cnt", sec_cnt, 5);

      // Asynchronous reset mid-sector.
      load_words(128, 128);
      start_sec(t0);
      while (cyc < t0 + 50) tick(1);
      chk("t7_streaming", sd_vld, 1);
      #2 rst = 1;
      #1;
      chk("t7_outs", {busy, rd_en, sd_vld, sof, eof, done, sd_data}, 0);
      chk("t7_cnts", {sec_cnt, 16'd0, stall_cnt}, 0);
      tick(1);
      rst = 0;
      tick(2);
      chk("t7_after", {busy, sec_cnt}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
